// File: rtl/gimli_stream_buffer_in_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gimli_stream_buffer_in_pipe
// Description : Packs DIN_WIDTH words into DOUT_WIDTH blocks through an
//               assembly stage (A) and a holding stage (H). A short final
//               message is zero-filled up to a full block before it moves
//               into H.
//               Optional macro GIMLI_STREAM_BUFFER_IN_PIPE_PAD_EN places a
//               0x01 marker byte right after the data of a short last block.
// Revision    : 1.0 - initial release
// ============================================================================
module gimli_stream_buffer_in_pipe #(
  parameter int DIN_WIDTH       = 32,
  parameter int DIN_SIZE_WIDTH  = 2,
  parameter int DOUT_WIDTH      = 128,
  parameter int DOUT_SIZE_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIN_WIDTH-1:0]       din,
  input  logic [DIN_SIZE_WIDTH:0]    din_size,
  input  logic                       din_last,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [DOUT_WIDTH-1:0]      dout,
  output logic [DOUT_SIZE_WIDTH:0]   dout_size,
  output logic                       dout_last,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [DOUT_SIZE_WIDTH:0]   size,
  output logic                       hold_full
);

  localparam int N_WORDS    = DOUT_WIDTH / DIN_WIDTH;
  localparam int CNT_W      = $clog2(N_WORDS + 1);
  localparam int DIN_BYTES  = DIN_WIDTH / 8;
  localparam int DOUT_BYTES = DOUT_WIDTH / 8;
  localparam int ISZ_W      = DIN_SIZE_WIDTH + 1;
  localparam int OSZ_W      = DOUT_SIZE_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Assembly stage
  logic [DOUT_WIDTH-1:0] a_data_q, a_data_d;
  logic [OSZ_W-1:0]      a_bytes_q, a_bytes_d;
  logic [CNT_W-1:0]      a_cnt_q, a_cnt_d;
  logic                  a_last_q, a_last_d;
  logic                  a_pad_q, a_pad_d;

  // Holding stage
  logic [DOUT_WIDTH-1:0] h_data_q, h_data_d;
  logic [OSZ_W-1:0]      h_size_q, h_size_d;
  logic                  h_last_q, h_last_d;
  logic                  h_valid_q, h_valid_d;

  logic                  a_complete;
  logic                  xfer;
  logic                  accept;
  logic [DIN_WIDTH-1:0]  din_masked;

  // Handshake decisions: a full A only drains when H is free or being emptied
  always_comb begin
    a_complete = (a_cnt_q == CNT_FULL);
    xfer       = a_complete && (!h_valid_q || dout_ready);
    din_ready  = !rst && !a_pad_q && (!a_complete || xfer);
    accept     = din_valid && din_ready;
  end

  // Zero every input byte at or above din_size
  always_comb begin
    din_masked = '0;
    for (int i = 0; i < DIN_BYTES; i++) begin
      din_masked[i*8 +: 8] = (ISZ_W'(i) < din_size) ? din[i*8 +: 8] : 8'h00;
    end
  end

  // Assembly next state: clear on transfer, then pad or accept a new word
  always_comb begin
    a_data_d  = a_data_q;
    a_bytes_d = a_bytes_q;
    a_cnt_d   = a_cnt_q;
    a_last_d  = a_last_q;
    a_pad_d   = a_pad_q;
    if (xfer) begin
      a_data_d  = '0;
      a_bytes_d = '0;
      a_cnt_d   = '0;
      a_last_d  = 1'b0;
      a_pad_d   = 1'b0;
    end
    if (a_pad_q) begin
      // Zero-fill word; byte count stays put
      a_data_d = {{DIN_WIDTH{1'b0}}, a_data_q[DOUT_WIDTH-1:DIN_WIDTH]};
      a_cnt_d  = a_cnt_q + CNT_ONE;
      if (a_cnt_q + CNT_ONE == CNT_FULL) begin
        a_pad_d = 1'b0;
      end
    end else if (accept) begin
      // Base is the cleared stage when a transfer happens in this cycle
      a_data_d  = {din_masked, a_data_d[DOUT_WIDTH-1:DIN_WIDTH]};
      a_bytes_d = a_bytes_d + OSZ_W'(din_size);
      a_last_d  = din_last;
      if (din_last && (a_cnt_d + CNT_ONE != CNT_FULL)) begin
        a_pad_d = 1'b1;
      end
      a_cnt_d = a_cnt_d + CNT_ONE;
    end
  end

  // Holding next state: load from A on transfer, otherwise drop when consumed
  always_comb begin
    h_data_d  = h_data_q;
    h_size_d  = h_size_q;
    h_last_d  = h_last_q;
    h_valid_d = h_valid_q;
    if (xfer) begin
      h_data_d  = a_data_q;
      h_size_d  = a_bytes_q;
      h_last_d  = a_last_q;
      h_valid_d = 1'b1;
`ifdef GIMLI_STREAM_BUFFER_IN_PIPE_PAD_EN
      // Marker byte just past the payload of a short last block
      for (int i = 0; i < DOUT_BYTES; i++) begin
        if (a_last_q && (OSZ_W'(i) == a_bytes_q)) begin
          h_data_d[i*8 +: 8] = 8'h01;
        end
      end
`else
      // Short last blocks keep plain zero fill
`endif
    end else if (h_valid_q && dout_ready) begin
      h_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_data_q  <= '0;
      a_bytes_q <= '0;
      a_cnt_q   <= '0;
      a_last_q  <= 1'b0;
      a_pad_q   <= 1'b0;
      h_data_q  <= '0;
      h_size_q  <= '0;
      h_last_q  <= 1'b0;
      h_valid_q <= 1'b0;
    end else begin
      a_data_q  <= a_data_d;
      a_bytes_q <= a_bytes_d;
      a_cnt_q   <= a_cnt_d;
      a_last_q  <= a_last_d;
      a_pad_q   <= a_pad_d;
      h_data_q  <= h_data_d;
      h_size_q  <= h_size_d;
      h_last_q  <= h_last_d;
      h_valid_q <= h_valid_d;
    end
  end

  assign dout       = h_data_q;
  assign dout_size  = h_size_q;
  assign dout_last  = h_last_q;
  assign dout_valid = h_valid_q;
  assign hold_full  = h_valid_q;
  assign size       = a_bytes_q;

endmodule
`default_nettype wire
